// File: rtl/trace_arbiter.sv
// trace_arbiter: shares the single trace-buffer write port between NUM_SRC
// trace sources (tiles 0..3, NoC 4). Each source has a one-entry holding
// register; a round-robin scheduler drains one held word per cycle into a
// registered output stage. Per-source saturating counters record samples
// that arrive while the holding register is still occupied.
//
// Optional feature macro: TRACE_ARB_TAG_EN
//   defined   -> tb_din carries the source id in its top TAGw bits
//   undefined -> tb_din is the held word unmodified
//
// Write interface semantics: tb_wr is a one-cycle write strobe, not a
// valid/ready pair. tb_full is looked at only in the grant cycle; a word that
// has already reached the output stage is written on the next cycle no
// matter what tb_full does then, so the buffer's full flag must keep one
// slot in reserve.
module trace_arbiter #(
    parameter int NUM_SRC = 5,
    parameter int Fpay    = 32,
    parameter int TAGw    = 3,
    parameter int DROPw   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*Fpay-1:0]  din_all,
    input  logic [NUM_SRC-1:0]       trig_all,
    input  logic [NUM_SRC-1:0]       src_mask,
    input  logic                     tb_full,
    output logic [Fpay-1:0]          tb_din,
    output logic                     tb_wr,
    output logic [TAGw-1:0]          tb_src,
    output logic [NUM_SRC-1:0]       pending,
    output logic [NUM_SRC*DROPw-1:0] drop_cnt_all
);

    logic [Fpay-1:0]    hold     [NUM_SRC];
    logic [DROPw-1:0]   drop_cnt [NUM_SRC];
    logic [NUM_SRC-1:0] pending_q;
    logic [TAGw-1:0]    ptr;

    logic               grant_valid;
    logic [TAGw-1:0]    grant_idx;
    logic [TAGw-1:0]    next_ptr;
    logic [NUM_SRC-1:0] granted;
    logic [NUM_SRC-1:0] cap_try;
    logic [NUM_SRC-1:0] cap_ok;
    logic [Fpay-1:0]    hold_g;
    logic [Fpay-1:0]    word_out;

    // Round-robin search: first pending source at or after ptr, wrapping.
    always_comb begin
        logic [TAGw-1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        if (!tb_full) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                idx = TAGw'((int'(ptr) + k) % NUM_SRC);
                if (!grant_valid && pending_q[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx;
                end
            end
        end
    end

    // Per-source grant flags and capture qualification; a held word that is
    // leaving this cycle frees its slot for a same-cycle capture.
    always_comb begin
        cap_try = trig_all & src_mask;
        granted = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            granted[i] = grant_valid && (grant_idx == TAGw'(i));
        end
        cap_ok   = cap_try & (~pending_q | granted);
        next_ptr = (grant_idx == TAGw'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        hold_g   = hold[grant_idx];
    end

`ifdef TRACE_ARB_TAG_EN
    assign word_out = {grant_idx, hold_g[Fpay-TAGw-1:0]};
`else
    assign word_out = hold_g;
`endif

    // Holding registers, valid flags, drop counters and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            ptr       <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold[i]     <= '0;
                drop_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cap_ok[i]) begin
                    hold[i]      <= din_all[i*Fpay +: Fpay];
                    pending_q[i] <= 1'b1;
                end else begin
                    if (granted[i]) begin
                        pending_q[i] <= 1'b0;
                    end
                    if (cap_try[i] && (drop_cnt[i] != {DROPw{1'b1}})) begin
                        drop_cnt[i] <= drop_cnt[i] + 1'b1;
                    end
                end
            end
            if (grant_valid) begin
                ptr <= next_ptr;
            end
        end
    end

    // Registered output stage: one write per granted cycle, data held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            tb_wr  <= 1'b0;
            tb_din <= '0;
            tb_src <= '0;
        end else begin
            tb_wr <= grant_valid;
            if (grant_valid) begin
                tb_din <= word_out;
                tb_src <= grant_idx;
            end
        end
    end

    assign pending = pending_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_drop_pack
        assign drop_cnt_all[i*DROPw +: DROPw] = drop_cnt[i];
    end

endmodule

// File: tb/tb_trace_arbiter.sv
// tb_trace_arbiter: scoreboard bench for trace_arbiter. Expected writes
// ({src, word}) are queued as stimulus is driven and compared in order as
// the DUT strobes tb_wr.
module tb_trace_arbiter;

    localparam int NUM_SRC = 5;
    localparam int Fpay    = 32;
    localparam int TAGw    = 3;
    localparam int DROPw   = 8;
    localparam int W       = TAGw + Fpay;

    logic                     clk;
    logic                     reset;
    logic [NUM_SRC*Fpay-1:0]  din_all;
    logic [NUM_SRC-1:0]       trig_all;
    logic [NUM_SRC-1:0]       src_mask;
    logic                     tb_full;
    logic [Fpay-1:0]          tb_din;
    logic                     tb_wr;
    logic [TAGw-1:0]          tb_src;
    logic [NUM_SRC-1:0]       pending;
    logic [NUM_SRC*DROPw-1:0] drop_cnt_all;

    logic [W-1:0] exp_q[$];
    int checks;
    int failures;

    trace_arbiter #(
        .NUM_SRC(NUM_SRC), .Fpay(Fpay), .TAGw(TAGw), .DROPw(DROPw)
    ) dut (
        .clk(clk), .reset(reset), .din_all(din_all), .trig_all(trig_all),
        .src_mask(src_mask), .tb_full(tb_full), .tb_din(tb_din),
        .tb_wr(tb_wr), .tb_src(tb_src), .pending(pending),
        .drop_cnt_all(drop_cnt_all)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word the buffer should see for a given source and held sample.
    function automatic logic [W-1:0] exp_word(input int src, input logic [Fpay-1:0] data);
        logic [TAGw-1:0] s;
        logic [Fpay-1:0] d;
        s = TAGw'(src);
`ifdef TRACE_ARB_TAG_EN
        d = {s, data[Fpay-TAGw-1:0]};
`else
        d = data;
`endif
        return {s, d};
    endfunction

    function automatic logic [DROPw-1:0] drop_of(input int src);
        return drop_cnt_all[src*DROPw +: DROPw];
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        trig_all = '0;
        din_all  = '0;
        tb_full  = 1'b0;
        src_mask = '1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_din(input int src, input logic [Fpay-1:0] v);
        din_all[src*Fpay +: Fpay] = v;
    endtask

    // Present a trigger vector for exactly one capture edge.
    task automatic pulse(input logic [NUM_SRC-1:0] t);
        trig_all = t;
        step();
        trig_all = '0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 60 && exp_q.size() > 0; n++) step();
        check(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && tb_wr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", {29'd0, tb_src, tb_din}, 64'd0);
            end else begin
                check("wr_word", 64'({tb_src, tb_din}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [Fpay-1:0] r1, r3;
        checks   = 0;
        failures = 0;
        do_reset();

        // reset state
        check("rst_tb_wr", 64'(tb_wr), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_tb_din", 64'(tb_din), 64'd0);
        check("rst_tb_src", 64'(tb_src), 64'd0);
        check("rst_drops", 64'(drop_cnt_all), 64'd0);

        // single sample, minimum latency
        set_din(0, 32'hA5A5_0001);
        exp_q.push_back(exp_word(0, 32'hA5A5_0001));
        pulse(5'b00001);
        check("lat_t1_wr", 64'(tb_wr), 64'd0);
        check("lat_t1_pend", 64'(pending), 64'd1);
        step();
        check("lat_t2_wr", 64'(tb_wr), 64'd1);
        check("lat_t2_pend", 64'(pending), 64'd0);
        step();
        check("lat_t3_wr", 64'(tb_wr), 64'd0);
        drain("single_drain");

        // all sources at once from ptr=0
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) begin
            set_din(i, Fpay'(i + 1));
            exp_q.push_back(exp_word(i, Fpay'(i + 1)));
        end
        pulse(5'b11111);
        for (int i = 0; i < NUM_SRC; i++) begin
            step();
            check("burst_wr", 64'(tb_wr), 64'd1);
        end
        step();
        check("burst_end_wr", 64'(tb_wr), 64'd0);
        check("burst_drops", 64'(drop_cnt_all), 64'd0);
        drain("burst_drain");

        // back-pressure holds everything, then drains in pointer order
        do_reset();
        tb_full = 1'b1;
        r1 = Fpay'($urandom);
        r3 = Fpay'($urandom);
        set_din(1, r1);
        pulse(5'b00010);
        step();
        set_din(3, r3);
        pulse(5'b01000);
        for (int n = 0; n < 10; n++) begin
            step();
            check("full_no_wr", 64'(tb_wr), 64'd0);
        end
        check("full_pending", 64'(pending), 64'b01010);
        exp_q.push_back(exp_word(1, r1));
        exp_q.push_back(exp_word(3, r3));
        tb_full = 1'b0;
        drain("full_drain");

        // drops while held, then saturation
        do_reset();
        tb_full = 1'b1;
        for (int n = 0; n < 4; n++) begin
            set_din(2, Fpay'(100 + n));
            pulse(5'b00100);
        end
        check("drop2_after4", 64'(drop_of(2)), 64'd3);
        check("drop2_pending", 64'(pending), 64'b00100);
        for (int n = 0; n < 300; n++) begin
            set_din(2, Fpay'($urandom_range(0, 1000)));
            pulse(5'b00100);
        end
        check("drop2_sat", 64'(drop_of(2)), 64'd255);
        check("drop0_clean", 64'(drop_of(0)), 64'd0);
        exp_q.push_back(exp_word(2, 32'd100));
        tb_full = 1'b0;
        drain("sat_drain");

        // masked source is neither captured nor counted
        do_reset();
        src_mask = 5'b11110;
        set_din(0, 32'h1234_5678);
        pulse(5'b00001);
        step();
        check("mask_pending", 64'(pending), 64'd0);
        check("mask_drop0", 64'(drop_of(0)), 64'd0);
        check("mask_no_wr", 64'(tb_wr), 64'd0);

        // NoC streams every cycle; tile 1 still gets through at once
        src_mask = '1;
        for (int k = 0; k < 12; k++) begin
            set_din(4, Fpay'(k));
            set_din(1, 32'h0000_1111);
            if (k < 3) exp_q.push_back(exp_word(4, Fpay'(k)));
            if (k == 3) begin
                exp_q.push_back(exp_word(1, 32'h0000_1111));
                exp_q.push_back(exp_word(4, Fpay'(3)));
            end
            if (k > 4) exp_q.push_back(exp_word(4, Fpay'(k)));
            pulse((k == 3) ? 5'b10010 : 5'b10000);
        end
        drain("stream_drain");
        check("stream_drop4", 64'(drop_of(4)), 64'd1);
        check("stream_drop1", 64'(drop_of(1)), 64'd0);

        // all-ones word from the NoC (tag visible when enabled)
        do_reset();
        set_din(4, 32'hFFFF_FFFF);
        exp_q.push_back(exp_word(4, 32'hFFFF_FFFF));
        pulse(5'b10000);
        drain("noc_ones_drain");

        // reset mid-operation discards held words, no write
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) set_din(i, Fpay'($urandom));
        pulse(5'b11111);
        reset = 1'b1;
        step();
        check("midrst_wr", 64'(tb_wr), 64'd0);
        check("midrst_pending", 64'(pending), 64'd0);
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            check("midrst_quiet", 64'(tb_wr), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
